// File: rtl/qpu_event_timer_pkg.sv
// Shared constants and helpers for the QPU event timer (trigger consumer side).
// Slice layout per channel: {timestamp, codeword}, codeword in the low bits.
package qpu_event_timer_pkg;

  localparam int QPU_TIME_WIDTH       = 32;
  localparam int QPU_EVENT_NUM        = 4;
  localparam int QPU_CW_WIDTH         = 8;
  localparam int QPU_EVENT_WIRE_WIDTH = QPU_EVENT_NUM * (QPU_TIME_WIDTH + QPU_CW_WIDTH);

  localparam int CW_MSB = QPU_CW_WIDTH - 1;
  localparam int TS_LSB = QPU_CW_WIDTH;

  // A head is late when (ts - now) mod 2^time_w has its MSB set.
  function automatic logic ts_is_late(input logic [63:0] slack, input int unsigned time_w);
    return slack[time_w-1];
  endfunction

endpackage

// File: rtl/qpu_event_fifo.sv
// Per-channel event FIFO: registered pointers, head is combinational from storage.
// A push on a full FIFO is accepted only when a pop frees a slot in the same cycle.
module qpu_event_fifo #(
  parameter int W     = 40,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  // Extra pointer MSB distinguishes full from empty.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/qpu_event_timer.sv
// Global time counter plus per-channel timed event release; strobes one cycle after the match.
// Optional QPU_EVT_LATE_FIRE_EN: late heads fire instead of being dropped silently.
module qpu_event_timer
  import qpu_event_timer_pkg::*;
#(
  parameter int TIME_W    = QPU_TIME_WIDTH,
  parameter int EVENT_NUM = QPU_EVENT_NUM,
  parameter int CW_W      = QPU_CW_WIDTH,
  parameter int DEPTH     = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               clk_ena,
  output logic [TIME_W-1:0]                  time_o,
  input  logic [EVENT_NUM-1:0]               evt_i_valid,
  input  logic [EVENT_NUM*(TIME_W+CW_W)-1:0] evt_i_data,
  output logic [EVENT_NUM-1:0]               evt_o_strobe,
  output logic [EVENT_NUM*CW_W-1:0]          evt_o_codeword,
  output logic [EVENT_NUM-1:0]               ovf_err,
  output logic [EVENT_NUM-1:0]               late_err,
  input  logic                               err_clr,
  output logic                               busy
);

  localparam int SLICE_W = TIME_W + CW_W;

  logic [TIME_W-1:0]    time_q;
  logic [EVENT_NUM-1:0] nonempty;
  logic [EVENT_NUM-1:0] late;
  logic [EVENT_NUM-1:0] emit;
  logic [EVENT_NUM-1:0] ovf;
  logic [CW_W-1:0]      head_cw [EVENT_NUM];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       time_q <= '0;
    else if (clk_ena) time_q <= time_q + TIME_W'(1);
  end

  assign time_o = time_q;

  for (genvar i = 0; i < EVENT_NUM; i++) begin : g_ch
    logic [SLICE_W-1:0] head;
    logic [TIME_W-1:0]  head_ts;
    logic [TIME_W-1:0]  slack;
    logic               empty;
    logic               full;
    logic               match;
    logic               pop;

    qpu_event_fifo #(.W(SLICE_W), .DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (evt_i_valid[i]),
      .push_data (evt_i_data[i*SLICE_W +: SLICE_W]),
      .pop       (pop),
      .head      (head),
      .full      (full),
      .empty     (empty)
    );

    assign head_ts    = head[SLICE_W-1:CW_W];
    assign head_cw[i] = head[CW_W-1:0];
    assign slack      = head_ts - time_q;
    assign match      = !empty && (head_ts == time_q);
    assign late[i]    = !empty && ts_is_late(64'(slack), TIME_W);
    assign pop        = match || late[i];
    assign nonempty[i] = !empty;
    // The pop frees the slot first, so a full FIFO that fires still takes the push.
    assign ovf[i]     = evt_i_valid[i] && full && !pop;
`ifdef QPU_EVT_LATE_FIRE_EN
    assign emit[i]    = pop;
`else
    assign emit[i]    = match;
`endif
  end

  assign busy = |nonempty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_o_strobe   <= '0;
      evt_o_codeword <= '0;
      ovf_err        <= '0;
      late_err       <= '0;
    end else begin
      evt_o_strobe <= emit;
      for (int i = 0; i < EVENT_NUM; i++) begin
        if (emit[i]) evt_o_codeword[i*CW_W +: CW_W] <= head_cw[i];
      end
      // Set has priority over clear.
      if (err_clr) begin
        ovf_err  <= ovf;
        late_err <= late;
      end else begin
        ovf_err  <= ovf_err | ovf;
        late_err <= late_err | late;
      end
    end
  end

endmodule

// File: tb/tb_qpu_event_timer.sv
// Directed bench for qpu_event_timer: vector table for the basic fire path, hand sequences for corners.
// A second, 8-bit-time instance exercises counter wrap within a short run.
module tb_qpu_event_timer;

  localparam int TW = 32;
  localparam int EN = 4;
  localparam int CW = 8;
  localparam int SW = TW + CW;

`ifdef QPU_EVT_LATE_FIRE_EN
  localparam bit LATE_FIRE = 1'b1;
`else
  localparam bit LATE_FIRE = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              clk_ena = 1'b0;
  logic              err_clr = 1'b0;
  logic [TW-1:0]     time_o;
  logic [EN-1:0]     evt_i_valid = '0;
  logic [EN*SW-1:0]  evt_i_data = '0;
  logic [EN-1:0]     evt_o_strobe;
  logic [EN*CW-1:0]  evt_o_codeword;
  logic [EN-1:0]     ovf_err;
  logic [EN-1:0]     late_err;
  logic              busy;

  logic              w_ena = 1'b0;
  logic [7:0]        w_time;
  logic [3:0]        w_valid = '0;
  logic [63:0]       w_data = '0;
  logic [3:0]        w_strobe;
  logic [31:0]       w_cw;
  logic [3:0]        w_ovf;
  logic [3:0]        w_late;
  logic              w_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  qpu_event_timer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .clk_ena        (clk_ena),
    .time_o         (time_o),
    .evt_i_valid    (evt_i_valid),
    .evt_i_data     (evt_i_data),
    .evt_o_strobe   (evt_o_strobe),
    .evt_o_codeword (evt_o_codeword),
    .ovf_err        (ovf_err),
    .late_err       (late_err),
    .err_clr        (err_clr),
    .busy           (busy)
  );

  qpu_event_timer #(.TIME_W(8)) dut_w (
    .clk            (clk),
    .rst_n          (rst_n),
    .clk_ena        (w_ena),
    .time_o         (w_time),
    .evt_i_valid    (w_valid),
    .evt_i_data     (w_data),
    .evt_o_strobe   (w_strobe),
    .evt_o_codeword (w_cw),
    .ovf_err        (w_ovf),
    .late_err       (w_late),
    .err_clr        (err_clr),
    .busy           (w_busy)
  );

  typedef struct packed {
    logic        ena;
    logic [3:0]  vld;
    logic [31:0] ts;
    logic [7:0]  cw;
    logic [31:0] exp_time;
    logic [3:0]  exp_strobe;
    logic [7:0]  exp_cw0;
    logic        exp_busy;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input int ch, input logic [31:0] ts, input logic [7:0] cw);
    evt_i_data = '0;
    evt_i_data[ch*SW +: SW] = {ts, cw};
    evt_i_valid = '0;
    evt_i_valid[ch] = 1'b1;
    step();
    evt_i_valid = '0;
  endtask

  function automatic logic [7:0] cw_of(input int ch);
    return evt_o_codeword[ch*CW +: CW];
  endfunction

  task automatic run_to(input logic [31:0] t);
    clk_ena = 1'b1;
    for (int i = 0; i < 2000 && time_o != t; i++) step();
    check("run_to time", 64'(time_o), 64'(t));
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs [12];
    logic [31:0] t0;
    logic [7:0]  last_cw;
    logic [7:0]  prev_w;
    int          n;
    bit          flag;

    vecs[0]  = '{1'b1, 4'h0, 32'd0,  8'h00, 32'd1,  4'h0, 8'h00, 1'b0};
    vecs[1]  = '{1'b1, 4'h0, 32'd0,  8'h00, 32'd2,  4'h0, 8'h00, 1'b0};
    vecs[2]  = '{1'b1, 4'h1, 32'd10, 8'h5A, 32'd3,  4'h0, 8'h00, 1'b1};
    vecs[3]  = '{1'b1, 4'h0, 32'd0,  8'h00, 32'd4,  4'h0, 8'h00, 1'b1};
    vecs[4]  = '{1'b1, 4'h0, 32'd0,  8'h00, 32'd5,  4'h0, 8'h00, 1'b1};
    vecs[5]  = '{1'b1, 4'h0, 32'd0,  8'h00, 32'd6,  4'h0, 8'h00, 1'b1};
    vecs[6]  = '{1'b1, 4'h0, 32'd0,  8'h00, 32'd7,  4'h0, 8'h00, 1'b1};
    vecs[7]  = '{1'b1, 4'h0, 32'd0,  8'h00, 32'd8,  4'h0, 8'h00, 1'b1};
    vecs[8]  = '{1'b1, 4'h0, 32'd0,  8'h00, 32'd9,  4'h0, 8'h00, 1'b1};
    vecs[9]  = '{1'b1, 4'h0, 32'd0,  8'h00, 32'd10, 4'h0, 8'h00, 1'b1};
    vecs[10] = '{1'b1, 4'h0, 32'd0,  8'h00, 32'd11, 4'h1, 8'h5A, 1'b0};
    vecs[11] = '{1'b1, 4'h0, 32'd0,  8'h00, 32'd12, 4'h0, 8'h5A, 1'b0};

    // Reset state
    repeat (2) step();
    check("reset time", 64'(time_o), 64'd0);
    check("reset strobe", 64'(evt_o_strobe), 64'd0);
    check("reset codeword", 64'(evt_o_codeword), 64'd0);
    check("reset ovf", 64'(ovf_err), 64'd0);
    check("reset late", 64'(late_err), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    rst_n = 1'b1;

    // Basic fire on ch0
    for (int r = 0; r < 12; r++) begin
      clk_ena     = vecs[r].ena;
      evt_i_data  = {EN{vecs[r].ts, vecs[r].cw}};
      evt_i_valid = vecs[r].vld;
      step();
      evt_i_valid = '0;
      check($sformatf("vec%0d time", r), 64'(time_o), 64'(vecs[r].exp_time));
      check($sformatf("vec%0d strobe", r), 64'(evt_o_strobe), 64'(vecs[r].exp_strobe));
      check($sformatf("vec%0d cw0", r), 64'(cw_of(0)), 64'(vecs[r].exp_cw0));
      check($sformatf("vec%0d busy", r), 64'(busy), 64'(vecs[r].exp_busy));
    end

    // Late head on ch3, then clear and set-over-clear priority
    run_to(32'd20);
    push(3, 32'd5, 8'hA5);
    check("late before detect", 64'(late_err), 64'd0);
    step();
    check("late set", 64'(late_err), 64'h8);
    check("late strobe", 64'(evt_o_strobe), LATE_FIRE ? 64'h8 : 64'h0);
    check("late codeword", 64'(cw_of(3)), LATE_FIRE ? 64'hA5 : 64'h00);
    check("late popped", 64'(busy), 64'd0);
    step();
    check("late strobe gone", 64'(evt_o_strobe), 64'd0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("late cleared", 64'(late_err), 64'd0);
    push(3, 32'd5, 8'h3C);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("late set beats clear", 64'(late_err), 64'h8);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("late cleared again", 64'(late_err), 64'd0);

    // Equal timestamps with time frozen fire on consecutive cycles
    t0 = time_o;
    clk_ena = 1'b0;
    push(1, t0 + 32'd1, 8'h11);
    push(1, t0 + 32'd1, 8'h22);
    clk_ena = 1'b1;
    step();
    clk_ena = 1'b0;
    step();
    check("equal ts first strobe", 64'(evt_o_strobe), 64'h2);
    check("equal ts first cw", 64'(cw_of(1)), 64'h11);
    step();
    check("equal ts second strobe", 64'(evt_o_strobe), 64'h2);
    check("equal ts second cw", 64'(cw_of(1)), 64'h22);
    step();
    check("equal ts done strobe", 64'(evt_o_strobe), 64'd0);
    check("equal ts time held", 64'(time_o), 64'(t0 + 32'd1));
    check("equal ts no late", 64'(late_err), 64'd0);

    // Time hold at 50, event at 55 fires after release
    clk_ena = 1'b1;
    push(0, 32'd55, 8'h77);
    run_to(32'd50);
    clk_ena = 1'b0;
    flag = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (time_o != 32'd50 || evt_o_strobe != 4'h0) flag = 1'b1;
    end
    check("hold frozen at 50", 64'(flag), 64'd0);
    clk_ena = 1'b1;
    for (int i = 0; i < 20 && !evt_o_strobe[0]; i++) step();
    check("hold fire time", 64'(time_o), 64'd56);
    check("hold fire cw", 64'(cw_of(0)), 64'h77);
    check("hold busy", 64'(busy), 64'd0);

    // Full ch2 whose head fires while a new push arrives
    t0 = time_o;
    clk_ena = 1'b0;
    push(2, t0 + 32'd1,  8'hB0);
    push(2, t0 + 32'd50, 8'hB1);
    push(2, t0 + 32'd51, 8'hB2);
    push(2, t0 + 32'd52, 8'hB3);
    clk_ena = 1'b1;
    step();
    clk_ena = 1'b0;
    push(2, t0 + 32'd53, 8'hB4);
    check("full+fire strobe", 64'(evt_o_strobe), 64'h4);
    check("full+fire cw", 64'(cw_of(2)), 64'hB0);
    check("full+fire no ovf", 64'(ovf_err), 64'd0);
    clk_ena = 1'b1;
    n = 0;
    last_cw = '0;
    for (int i = 0; i < 100 && time_o != t0 + 32'd55; i++) begin
      step();
      if (evt_o_strobe[2]) begin
        n++;
        last_cw = cw_of(2);
      end
    end
    check("full+fire remaining fires", 64'(n), 64'd4);
    check("full+fire last cw", 64'(last_cw), 64'hB4);
    check("full+fire ovf still 0", 64'(ovf_err), 64'd0);

    // Asynchronous reset with three channels pending and an error set
    t0 = time_o;
    clk_ena = 1'b0;
    push(0, t0 + 32'd100, 8'h01);
    push(1, t0 + 32'd100, 8'h02);
    push(2, t0 + 32'd100, 8'h03);
    push(3, t0 - 32'd10,  8'h44);
    step();
    check("pre-reset late", 64'(late_err), 64'h8);
    check("pre-reset busy", 64'(busy), 64'd1);
    pulse_reset();
    check("async reset time", 64'(time_o), 64'd0);
    check("async reset busy", 64'(busy), 64'd0);
    check("async reset late", 64'(late_err), 64'd0);
    check("async reset strobe", 64'(evt_o_strobe), 64'd0);
    check("async reset codeword", 64'(evt_o_codeword), 64'd0);
    step();
    rst_n = 1'b1;
    clk_ena = 1'b1;
    flag = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (evt_o_strobe != 4'h0 || busy) flag = 1'b1;
    end
    check("post-reset quiet", 64'(flag), 64'd0);

    // Overflow: five pushes into a depth-4 FIFO on ch1
    clk_ena = 1'b0;
    pulse_reset();
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      push(1, 32'd100 + 32'(k), 8'h64 + 8'(k));
      if (k == 3) check("ovf after 4 pushes", 64'(ovf_err), 64'd0);
    end
    check("ovf after 5th push", 64'(ovf_err), 64'h2);
    check("ovf time still 0", 64'(time_o), 64'd0);
    clk_ena = 1'b1;
    n = 0;
    for (int i = 0; i < 200 && time_o != 32'd106; i++) begin
      step();
      if (evt_o_strobe[1]) begin
        n++;
        check("ovf fire cw", 64'(cw_of(1)), 64'(8'(time_o - 32'd1)));
      end
    end
    check("ovf fire count", 64'(n), 64'd4);
    check("ovf busy drained", 64'(busy), 64'd0);
    check("ovf no late", 64'(late_err), 64'd0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("ovf cleared", 64'(ovf_err), 64'd0);

    // Counter wrap on the 8-bit instance
    clk_ena = 1'b0;
    w_ena = 1'b1;
    for (int i = 0; i < 300 && w_time != 8'd200; i++) step();
    check("wrap reach 200", 64'(w_time), 64'd200);
    w_data = '0;
    w_data[15:0] = {8'd0, 8'hC3};
    w_valid = 4'h1;
    step();
    w_valid = '0;
    flag = 1'b0;
    for (int i = 0; i < 100 && !w_strobe[0]; i++) begin
      prev_w = w_time;
      step();
      if (prev_w == 8'hFF && w_time == 8'h00) flag = 1'b1;
    end
    check("wrap 0xFF->0 seen", 64'(flag), 64'd1);
    check("wrap fire time", 64'(w_time), 64'd1);
    check("wrap fire cw", 64'(w_cw[7:0]), 64'hC3);
    check("wrap no late", 64'(w_late), 64'd0);
    check("wrap busy", 64'(w_busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
